// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store controller: access-width codes, FSM states
// and the size-to-base-mask helpers.
package lsu_ctrl_pkg;

    localparam int XLEN       = 64;
    localparam int ImmWidth   = XLEN;
    localparam int WdtTypeCnt = 4;

    localparam logic [WdtTypeCnt-1:0] Wdt8  = 4'b0001;
    localparam logic [WdtTypeCnt-1:0] Wdt16 = 4'b0010;
    localparam logic [WdtTypeCnt-1:0] Wdt32 = 4'b0100;
    localparam logic [WdtTypeCnt-1:0] Wdt64 = 4'b1000;

    localparam logic [7:0] MaskB = 8'h01;
    localparam logic [7:0] MaskH = 8'h03;
    localparam logic [7:0] MaskW = 8'h0F;
    localparam logic [7:0] MaskD = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] wdt_base_mask(input logic [WdtTypeCnt-1:0] wdt);
        logic [7:0] m;
        case (wdt)
            Wdt8:    m = MaskB;
            Wdt16:   m = MaskH;
            Wdt32:   m = MaskW;
            Wdt64:   m = MaskD;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Non-one-hot codes are never flagged; they still run a transaction.
    function automatic logic wdt_misaligned(input logic [WdtTypeCnt-1:0] wdt,
                                            input logic [2:0] off);
        logic mis;
        case (wdt)
            Wdt16:   mis = off[0];
            Wdt32:   mis = |off[1:0];
            Wdt64:   mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_lane_ext.sv
// lsu_lane_ext: right-aligns 8-byte read data by the byte lane offset and
// sign/zero-extends it to the requested access width.
module lsu_lane_ext
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN  = lsu_ctrl_pkg::XLEN,
    parameter int WDT_W = lsu_ctrl_pkg::WdtTypeCnt
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [2:0]       off,
    input  logic [WDT_W-1:0] wdt,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (wdt)
            Wdt8:    data = {{(XLEN-8){~is_unsigned & shifted[7]}},   shifted[7:0]};
            Wdt16:   data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            Wdt32:   data = {{(XLEN-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
            Wdt64:   data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EXU and the data-memory port: one operation at a time.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_ctrl
#(
    parameter int XLEN  = lsu_ctrl_pkg::XLEN,
    parameter int WDT_W = lsu_ctrl_pkg::WdtTypeCnt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wen,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [XLEN-1:0]  in_wdata,
    input  logic [WDT_W-1:0] in_wdt_op,
    input  logic             in_unsigned,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    output logic             mem_req_wen,
    output logic [XLEN-1:0]  mem_req_wdata,
    output logic [7:0]       mem_req_wmask,
    input  logic             mem_resp_valid,
    input  logic [XLEN-1:0]  mem_resp_rdata,
    output logic             mem_resp_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rdata
`ifdef LSU_MISALIGN_CHK_EN
    ,
    output logic             out_misalign
`endif
);

    import lsu_ctrl_pkg::*;

    lsu_state_e       state_q, state_d;
    logic             wen_q, wen_d;
    logic             uns_q, uns_d;
    logic [2:0]       off_q, off_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [7:0]       wmask_q, wmask_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  ext_data;
    logic [2:0]       in_off;
    logic             in_mis;

    assign in_off = in_addr[2:0];

`ifdef LSU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    assign in_mis       = wdt_misaligned(in_wdt_op, in_off);
    assign out_misalign = misalign_q;
`else
    assign in_mis = 1'b0;
`endif

    lsu_lane_ext #(
        .XLEN (XLEN),
        .WDT_W(WDT_W)
    ) u_lane_ext (
        .rdata      (mem_resp_rdata),
        .off        (off_q),
        .wdt        (wdt_q),
        .is_unsigned(uns_q),
        .data       (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        uns_d    = uns_q;
        off_d    = off_q;
        wdt_d    = wdt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        result_d = result_q;
`ifdef LSU_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wen_d    = in_wen;
                    uns_d    = in_unsigned;
                    off_d    = in_off;
                    wdt_d    = in_wdt_op;
                    addr_d   = {in_addr[XLEN-1:3], 3'b000};
                    // Lane shift and mask are precomputed so the request is a pure register.
                    wdata_d  = in_wdata << {in_off, 3'b000};
                    wmask_d  = wdt_base_mask(in_wdt_op) << in_off;
                    result_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
                    misalign_d = in_mis;
`endif
                    state_d  = in_mis ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    result_d = wen_q ? '0 : ext_data;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            uns_q    <= 1'b0;
            off_q    <= '0;
            wdt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            result_q <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            wdt_q    <= wdt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            result_q <= result_d;
`ifdef LSU_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign mem_req_valid  = (state_q == REQ);
    assign mem_resp_ready = (state_q == WAIT);
    assign out_valid      = (state_q == DONE);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign out_rdata      = result_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected requests/results,
// a negedge monitor pops and compares them on every handshake.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, in_unsigned;
    logic [63:0] in_addr, in_wdata;
    logic [3:0]  in_wdt_op;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [63:0] mem_resp_rdata;
    logic        out_valid, out_ready;
    logic [63:0] out_rdata;
`ifdef LSU_MISALIGN_CHK_EN
    logic        out_misalign;
`endif

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(64), .WDT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_wdt_op     (in_wdt_op),
        .in_unsigned   (in_unsigned),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_ready(mem_resp_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata)
`ifdef LSU_MISALIGN_CHK_EN
        ,
        .out_misalign  (out_misalign)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    req_t mon_r;
    res_t mon_o;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Monitor: compares presented request/result against the queue head every cycle
    // they are valid, so a stalled transfer must also stay stable.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    timeout("unexpected_req");
                end else begin
                    mon_r = req_q[0];
                    check("req_addr", mem_req_addr, mon_r.addr);
                    check("req_wen", {63'd0, mem_req_wen}, {63'd0, mon_r.wen});
                    if (mon_r.wen) begin
                        check("req_wdata", mem_req_wdata, mon_r.wdata);
                        check("req_wmask", {56'd0, mem_req_wmask}, {56'd0, mon_r.wmask});
                    end
                    if (mem_req_ready) void'(req_q.pop_front());
                end
            end
            if (out_valid) begin
                if (res_q.size() == 0) begin
                    timeout("unexpected_out");
                end else begin
                    mon_o = res_q[0];
                    check("out_rdata", out_rdata, mon_o.rdata);
`ifdef LSU_MISALIGN_CHK_EN
                    check("out_misalign", {63'd0, out_misalign}, {63'd0, mon_o.mis});
`endif
                    if (out_ready) void'(res_q.pop_front());
                end
            end
            if (mem_req_valid || mem_resp_ready || out_valid)
                check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
        check({tag, "_req_wen"}, {63'd0, mem_req_wen}, 64'd0);
        check({tag, "_resp_ready"}, {63'd0, mem_resp_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_req_addr"}, mem_req_addr, 64'd0);
        check({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
        check({tag, "_req_wmask"}, {56'd0, mem_req_wmask}, 64'd0);
        check({tag, "_out_rdata"}, out_rdata, 64'd0);
`ifdef LSU_MISALIGN_CHK_EN
        check({tag, "_misalign"}, {63'd0, out_misalign}, 64'd0);
`endif
    endtask

    task automatic do_op(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [3:0] wdt, input logic uns, input logic [63:0] rdata,
                         input int req_stall, input int out_stall,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                         input logic [63:0] exp_rdata, input int exp_lat);
        req_t r;
        res_t o;
        int   lat;
        int   k;
        r.addr  = addr & ~64'h7;
        r.wen   = wen;
        r.wdata = exp_wdata;
        r.wmask = exp_wmask;
        req_q.push_back(r);
        o.rdata = exp_rdata;
        o.mis   = 1'b0;
        res_q.push_back(o);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid    = 1'b1;
        in_wen      = wen;
        in_addr     = addr;
        in_wdata    = wdata;
        in_wdt_op   = wdt;
        in_unsigned = uns;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        // Junk response outside WAIT must be ignored.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (req_stall) begin @(posedge clk); #1; lat++; end
        mem_req_ready = 1'b1;
        k = 0;
        while (!mem_req_valid && k < 16) begin @(posedge clk); #1; k++; lat++; end
        if (k >= 16) timeout("req_wait");
        @(posedge clk); #1; lat++;
        mem_req_ready  = 1'b0;
        mem_resp_rdata = rdata;
        k = 0;
        while (!mem_resp_ready && k < 16) begin @(posedge clk); #1; k++; lat++; end
        if (k >= 16) timeout("resp_wait");
        @(posedge clk); #1; lat++;
        mem_resp_valid = 1'b0;
        repeat (out_stall) begin @(posedge clk); #1; lat++; end
        out_ready = 1'b1;
        k = 0;
        while (!out_valid && k < 16) begin @(posedge clk); #1; k++; lat++; end
        if (k >= 16) timeout("out_wait");
        @(posedge clk); #1; lat++;
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        rst = 1'b0;
        in_valid = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0;
        in_wdt_op = '0; in_unsigned = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_values("rst0");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        check_reset_values("post_rst");

        // Load byte signed/unsigned, minimum latency
        do_op(0, 64'h8000_0003, 64'h0, Wdt8, 0, 64'h0000_0000_8000_0000, 0, 0,
              64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 3);
        do_op(0, 64'h8000_0003, 64'h0, Wdt8, 1, 64'h0000_0000_8000_0000, 0, 0,
              64'h0, 8'h00, 64'h0000_0000_0000_0080, 3);
        // Store word at lane 4
        do_op(1, 64'h8000_0004, 64'h1234_5678, Wdt32, 0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0,
              64'h1234_5678_0000_0000, 8'hF0, 64'h0, 3);
        // Back-pressure: 3 request stalls, 2 result stalls
        do_op(0, 64'h1000_0002, 64'h0, Wdt16, 0, 64'h0000_0000_8001_0000, 3, 2,
              64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 8);
        do_op(0, 64'h1000_0006, 64'h0, Wdt16, 1, 64'hFFEE_0000_0000_0000, 0, 0,
              64'h0, 8'h00, 64'h0000_0000_0000_FFEE, 3);
        do_op(0, 64'h1000_0004, 64'h0, Wdt32, 0, 64'h8765_4321_0000_0000, 1, 0,
              64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 4);
        do_op(0, 64'h1000_0004, 64'h0, Wdt32, 1, 64'h8765_4321_0000_0000, 0, 1,
              64'h0, 8'h00, 64'h0000_0000_8765_4321, 4);
        do_op(0, 64'h2000_0008, 64'h0, Wdt64, 0, 64'h0123_4567_89AB_CDEF, 0, 0,
              64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 3);
        do_op(1, 64'h2000_0007, 64'hFFFF_FFFF_FFFF_FFA5, Wdt8, 0, 64'h0, 0, 0,
              64'hA500_0000_0000_0000, 8'h80, 64'h0, 3);
        do_op(1, 64'h5000_0000, 64'h0011_2233_4455_6677, Wdt64, 0, 64'h0, 0, 0,
              64'h0011_2233_4455_6677, 8'hFF, 64'h0, 3);
        // Non-one-hot width codes
        do_op(1, 64'h5000_0002, 64'hAAAA, 4'b0110, 0, 64'h0, 0, 0,
              64'h0000_0000_AAAA_0000, 8'h00, 64'h0, 3);
        do_op(0, 64'h5000_0000, 64'h0, 4'b0000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
              64'h0, 8'h00, 64'h0, 3);

`ifdef LSU_MISALIGN_CHK_EN
        begin
            res_t o;
            o.rdata = '0;
            o.mis   = 1'b1;
            res_q.push_back(o);
            in_valid = 1'b1; in_wen = 1'b0; in_addr = 64'h4000_0001;
            in_wdt_op = Wdt16; in_unsigned = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("mis_no_req", {63'd0, mem_req_valid}, 64'd0);
            check("mis_out_valid_c1", {63'd0, out_valid}, 64'd1);
            check("mis_flag", {63'd0, out_misalign}, 64'd1);
            @(posedge clk); #1;
            check("mis_holds", {63'd0, out_valid}, 64'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("mis_back_idle", {63'd0, in_ready}, 64'd1);
        end
`else
        // Misaligned accesses go out as-is, with lanes beyond 7 dropped
        do_op(1, 64'h6000_0006, 64'h1122_3344, Wdt32, 0, 64'h0, 0, 0,
              64'h3344_0000_0000_0000, 8'hC0, 64'h0, 3);
        do_op(0, 64'h6000_0007, 64'h0, Wdt16, 0, 64'hAB00_0000_0000_0000, 0, 0,
              64'h0, 8'h00, 64'h0000_0000_0000_00AB, 3);
`endif

        // Asynchronous reset while waiting for the response
        r.addr = 64'h3000_0000; r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
        req_q.push_back(r);
        in_valid = 1'b1; in_wen = 1'b0; in_addr = 64'h3000_0004;
        in_wdt_op = Wdt32; in_unsigned = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("pre_rst_wait", {63'd0, mem_resp_ready}, 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("mid_rst");
        @(posedge clk); #1 rst = 1'b0;
        do_op(0, 64'h3000_0001, 64'h0, Wdt8, 1, 64'h0000_0000_0000_7F00, 0, 0,
              64'h0, 8'h00, 64'h0000_0000_0000_007F, 3);

        @(posedge clk); #1;
        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("res_q_empty", 64'(res_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage and the data-memory port of the RV64 core. Accepts one memory operation at a time from EXU and drives a valid/ready request to data memory. It waits for the response, then lane-aligns and sign/zero-extends load data before handing a 64-bit result to write-back. It is the single owner of the byte-lane shifting, write-mask generation and load extension for the data path.

## Interface

Parameters:
- `XLEN`, 64: data/address width (equals `ImmWidth`).
- `WDT_W`, 4: width of the one-hot access-width code (equals `WdtTypeCnt`). Bit encodings are `Wdt8`/`Wdt16`/`Wdt32`/`Wdt64`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: EXU has an operation.
- `in_ready` out 1: controller can accept an operation.
- `in_wen` in 1: 1 = store, 0 = load.
- `in_addr` in XLEN: byte address.
- `in_wdata` in XLEN: store data, right-justified.
- `in_wdt_op` in WDT_W: one-hot access width.
- `in_unsigned` in 1: zero-extend the load when 1.
- `mem_req_valid` out 1: request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out XLEN: `in_addr` with bits [2:0] cleared.
- `mem_req_wen` out 1: write request.
- `mem_req_wdata` out XLEN: lane-shifted store data.
- `mem_req_wmask` out 8: byte enables.
- `mem_resp_valid` in 1: response/ack valid.
- `mem_resp_rdata` in XLEN: 8-byte-aligned read data.
- `mem_resp_ready` out 1: controller accepts the response.
- `out_valid` out 1: result available.
- `out_ready` in 1: write-back consumes the result.
- `out_rdata` out XLEN: extended load data. Always 0 for stores.
- `out_misalign` out 1: misaligned-access flag. Present only with `LSU_MISALIGN_CHK_EN`.

## Operation

- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch all `in_*` fields and go to REQ. With `LSU_MISALIGN_CHK_EN` and a misaligned access, go to DONE instead.
- REQ: `mem_req_valid`=1, with fields held stable from the latch. On `mem_req_ready`, go to WAIT.
- WAIT: `mem_resp_ready`=1. On `mem_resp_valid`, capture the processed data into the result register and go to DONE. Stores also wait for the ack.
- DONE: `out_valid`=1 with the result held. On `out_ready`, go to IDLE.
- Lane offset `off` = `addr[2:0]`.
- Write data: `mem_req_wdata` = `wdata << (8*off)`.
- Write mask: `mem_req_wmask` = (0x01/0x03/0x0F/0xFF for 8/16/32/64) `<< off`, truncated to 8 bits.
- Load data: `shifted = rdata >> (8*off)`.
  - Low 8/16/32/64 bits of `shifted` are sign-extended, or zero-extended if `in_unsigned`.
  - Wdt64 passes through unchanged.
- Non-one-hot `in_wdt_op`: load result is 0 and store wmask is 0x00. The memory transaction is still performed.
- `mem_resp_valid` outside WAIT is ignored, because `mem_resp_ready`=0 there.

## Timing

- Reset values:
  - State = IDLE.
  - `in_ready`=1.
  - `mem_req_valid`, `mem_req_wen`, `mem_resp_ready`, `out_valid`, `out_misalign` = 0.
  - `mem_req_addr`, `mem_req_wdata`, `mem_req_wmask`, `out_rdata` = 0.
- Minimum latency: accept at edge 0, request handshake at edge 1, response at edge 2, `out_valid` from cycle 3. Every stall adds cycles 1:1.
- All control outputs are decoded from state registers. No combinational path runs from `in_*`, `mem_*` or `out_ready` to any valid/ready output.
- Throughput is one operation per 4 cycles at best. There is no overlap.
- Reset asserted mid-operation aborts the operation immediately. Memory shares `rst`, so no stale response may follow.

## Configuration

- `LSU_MISALIGN_CHK_EN` defined:
  - Misaligned means `off` is not a multiple of the access size.
  - A misaligned access issues no memory request, goes straight to DONE with `out_misalign`=1 and `out_rdata`=0, and still waits for `out_ready`.
- Undefined:
  - The port is absent and no check is made.
  - Misaligned accesses are issued as-is. Bytes beyond lane 7 are dropped from the mask and data.

## Structure

- Shared package/defines header: the `Wdt*` encodings, `WdtTypeCnt`, `XLEN`, the FSM state encoding, and the size-to-base-mask constants.
- One sub-module, `lsu_lane_ext`: combinational right-shift plus sign/zero extension of read data, instantiated once in the WAIT-capture path.

## Test plan

- Load byte: addr 0x8000_0003, Wdt8, signed, rdata 0x0000_0000_8000_0000 -> `out_rdata` 0xFFFF_FFFF_FFFF_FF80.
- Same rdata, Wdt8, unsigned -> 0x0000_0000_0000_0080.
- Store word: addr 0x8000_0004, wdata 0x1234_5678, Wdt32 -> `mem_req_wmask` 0xF0, `mem_req_wdata` 0x1234_5678_0000_0000, `mem_req_addr` 0x8000_0000.
- Back-pressure: `mem_req_ready` low for 3 cycles and `out_ready` low for 2 cycles -> request and result held stable, `in_ready`=0 throughout, total latency 8 cycles.
- With `LSU_MISALIGN_CHK_EN`: Wdt16 at addr 0x...1 -> no `mem_req_valid`, `out_valid` with `out_misalign`=1 at cycle 1.
- `rst` pulse while in WAIT -> all outputs return to their reset values asynchronously. A following load completes normally.
